// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED frame scheduler:
//   - state_t              : scheduler FSM encoding
//   - COLOR_W              : width of one GRB colour word
//   - DEFAULT_LATCH_CYCLES : latch/reset hold time (80 us) for a 25 MHz clock
//   - clog2_min1()         : bit width needed to index/count n values, never 0
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int COLOR_W = 24;

  localparam int DEFAULT_CLK_HZ       = 25_000_000;
  localparam int LATCH_US             = 80;
  localparam int DEFAULT_LATCH_CYCLES = (DEFAULT_CLK_HZ / 1_000_000) * LATCH_US;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Bits needed to represent the values 0 .. n-1; at least 1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_sched_timer.sv
// ---------------------------------------------------------------------------
// led_sched_timer
// Loadable down-counter with a zero flag. load has priority over en; the
// counter stops at zero rather than wrapping.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count <= RESET_VAL)
//   load       : load load_val this cycle
//   load_val   : value to load
//   en         : decrement by one when count is non-zero
//   zero       : count == 0
// ---------------------------------------------------------------------------
module led_sched_timer #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
// Walks the LED buffer in index order, hands each 24-bit colour word to the
// serializer, then holds the line in latch for LATCH_CYCLES. Update requests
// arriving while a frame is in flight collapse into one follow-up frame.
// Optional auto refresh re-sends the frame after REFRESH_CYCLES idle cycles.
//
// Handshake: tx_data_o is transferred on a cycle where tx_valid_o and
// tx_ready_i are both high. Once tx_valid_o rises, it and tx_data_o stay
// constant until that transfer; tx_ready_i is ignored while tx_valid_o is low.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   update_i      : one-cycle frame request
//   rd_en_o       : buffer read strobe, rd_data_i valid one cycle later
//   rd_addr_o     : buffer read index
//   rd_data_i     : buffer word
//   tx_data_o     : colour word to serializer
//   tx_valid_o    : tx_data_o valid
//   tx_ready_i    : serializer accepts the word
//   latch_o       : hold the LED line low (latch/reset)
//   busy_o        : frame in progress
//   frame_done_o  : one-cycle pulse at the end of the latch interval
//   dbg_state     : current FSM state (led_pkg::state_t encoding)
// All outputs are registered.
// ---------------------------------------------------------------------------
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int LED_CNT        = 3,
  parameter int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
  parameter int REFRESH_CYCLES = 0,
  parameter int IDX_W          = clog2_min1(LED_CNT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update_i,
  output logic               rd_en_o,
  output logic [IDX_W-1:0]   rd_addr_o,
  input  logic [COLOR_W-1:0] rd_data_i,
  output logic [COLOR_W-1:0] tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               latch_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic [2:0]         dbg_state
);

  localparam int LAT_W    = clog2_min1(LATCH_CYCLES);
  localparam int REF_LOAD = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
  localparam int REF_W    = clog2_min1(REF_LOAD + 1);

  localparam logic [LAT_W-1:0] LATCH_LOAD = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LOADV  = REF_W'(REF_LOAD);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LED_CNT - 1);
  localparam bit               REF_ON     = (REFRESH_CYCLES != 0);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             pending;

  logic latch_start;
  logic latch_zero;
  logic ref_zero;
  logic ref_fire;

  assign dbg_state = state;

  // Latch timer is loaded with LATCH_CYCLES-1 on the last handshake, so
  // latch_o stays high for counts LATCH_CYCLES-1 down to 0.
  assign latch_start = (state == ST_SEND) && tx_ready_i && (idx == LAST_IDX);

  led_sched_timer #(
    .W         (LAT_W),
    .RESET_VAL ('0)
  ) u_latch_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (latch_start),
    .load_val (LATCH_LOAD),
    .en       (state == ST_LATCH),
    .zero     (latch_zero)
  );

  // Refresh timer is held at REFRESH_CYCLES-1 in every non-idle state and
  // counts down only in IDLE; reaching zero means REFRESH_CYCLES idle cycles
  // have elapsed since the last frame (or since reset).
  led_sched_timer #(
    .W         (REF_W),
    .RESET_VAL (REF_LOADV)
  ) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state != ST_IDLE),
    .load_val (REF_LOADV),
    .en       (REF_ON && (state == ST_IDLE)),
    .zero     (ref_zero)
  );

  assign ref_fire = REF_ON && (state == ST_IDLE) && ref_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pending      <= 1'b0;
      rd_en_o      <= 1'b0;
      rd_addr_o    <= '0;
      tx_data_o    <= '0;
      tx_valid_o   <= 1'b0;
      latch_o      <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      rd_en_o      <= 1'b0;
      frame_done_o <= 1'b0;

      // Requests during a frame are remembered; DONE clears this below,
      // and that later assignment wins.
      if (update_i && (state != ST_IDLE)) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (update_i || ref_fire) begin
            idx       <= '0;
            rd_addr_o <= '0;
            rd_en_o   <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: state <= ST_WAIT;

        ST_WAIT: begin
          tx_data_o  <= rd_data_i;
          tx_valid_o <= 1'b1;
          state      <= ST_SEND;
        end

        ST_SEND: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            if (idx == LAST_IDX) begin
              latch_o <= 1'b1;
              state   <= ST_LATCH;
            end else begin
              idx       <= idx + 1'b1;
              rd_addr_o <= idx + 1'b1;
              rd_en_o   <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end

        ST_LATCH: begin
          if (latch_zero) begin
            latch_o      <= 1'b0;
            frame_done_o <= 1'b1;
            state        <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (pending || update_i) begin
            pending   <= 1'b0;
            idx       <= '0;
            rd_addr_o <= '0;
            rd_en_o   <= 1'b1;
            state     <= ST_FETCH;
          end else begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
// Three scheduler instances share one clock and one LED buffer model:
//   u_main : LED_CNT=3, LATCH=2000, no refresh (frame, backpressure,
//            coalescing, reset mid-frame)
//   u_ref  : LED_CNT=3, LATCH=100, REFRESH=5000 (auto refresh)
//   u_one  : LED_CNT=1, LATCH=20 (single LED)
// Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;
  import led_pkg::*;

  localparam int LATCH_M = 2000;
  localparam int LATCH_R = 100;
  localparam int REF_R   = 5000;
  localparam int LATCH_O = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m = 1'b1;
  logic rst_r = 1'b1;
  logic rst_o = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [23:0] mem [0:2];

  // ---------------- DUT signals ----------------
  logic        upd_m = 1'b0, rdy_m = 1'b1;
  logic        rd_en_m, txv_m, latch_m, busy_m, done_m;
  logic [1:0]  addr_m;
  logic [23:0] rdata_m = '0, txd_m;
  logic [2:0]  st_m;

  logic        upd_r = 1'b0, rdy_r = 1'b1;
  logic        rd_en_r, txv_r, latch_r, busy_r, done_r;
  logic [1:0]  addr_r;
  logic [23:0] rdata_r = '0, txd_r;
  logic [2:0]  st_r;

  logic        upd_o = 1'b0, rdy_o = 1'b1;
  logic        rd_en_o1, txv_o, latch_o1, busy_o1, done_o;
  logic [0:0]  addr_o;
  logic [23:0] rdata_o = '0, txd_o;
  logic [2:0]  st_o;

  led_frame_scheduler #(.LED_CNT(3), .LATCH_CYCLES(LATCH_M), .REFRESH_CYCLES(0)) u_main (
    .clk(clk), .reset(rst_m), .update_i(upd_m), .rd_en_o(rd_en_m), .rd_addr_o(addr_m),
    .rd_data_i(rdata_m), .tx_data_o(txd_m), .tx_valid_o(txv_m), .tx_ready_i(rdy_m),
    .latch_o(latch_m), .busy_o(busy_m), .frame_done_o(done_m), .dbg_state(st_m));

  led_frame_scheduler #(.LED_CNT(3), .LATCH_CYCLES(LATCH_R), .REFRESH_CYCLES(REF_R)) u_ref (
    .clk(clk), .reset(rst_r), .update_i(upd_r), .rd_en_o(rd_en_r), .rd_addr_o(addr_r),
    .rd_data_i(rdata_r), .tx_data_o(txd_r), .tx_valid_o(txv_r), .tx_ready_i(rdy_r),
    .latch_o(latch_r), .busy_o(busy_r), .frame_done_o(done_r), .dbg_state(st_r));

  led_frame_scheduler #(.LED_CNT(1), .LATCH_CYCLES(LATCH_O), .REFRESH_CYCLES(0)) u_one (
    .clk(clk), .reset(rst_o), .update_i(upd_o), .rd_en_o(rd_en_o1), .rd_addr_o(addr_o),
    .rd_data_i(rdata_o), .tx_data_o(txd_o), .tx_valid_o(txv_o), .tx_ready_i(rdy_o),
    .latch_o(latch_o1), .busy_o(busy_o1), .frame_done_o(done_o), .dbg_state(st_o));

  // Buffer model: word valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_m)  rdata_m <= mem[addr_m];
    if (rd_en_r)  rdata_r <= mem[addr_r];
    if (rd_en_o1) rdata_o <= mem[addr_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event (value %0h) expected none", name, act);
  endtask

  // ---------------- scoreboard: main ----------------
  logic [23:0] exp_tx_q[$];
  logic [1:0]  exp_addr_q[$];
  logic        exp_follow_q[$];
  int   done_m_cnt = 0;
  int   stall_m    = 0;
  int   latch_run  = 0;
  logic prev_latch = 1'b0;
  logic follow_chk = 1'b0;
  logic follow_exp = 1'b0;

  always @(negedge clk) begin
    if (rst_m) begin
      latch_run  = 0;
      prev_latch = 1'b0;
      follow_chk = 1'b0;
    end else begin
      if (follow_chk) begin
        if (follow_exp) check("followup_fetch", {30'd0, rd_en_m, (addr_m == 2'd0)}, 32'd3);
        else            check("idle_after_done", {31'd0, busy_m}, 32'd0);
        follow_chk = 1'b0;
      end
      if (rd_en_m) begin
        if (exp_addr_q.size() == 0) fail_extra("extra_read", {30'd0, addr_m});
        else check("rd_addr", {30'd0, addr_m}, {30'd0, exp_addr_q.pop_front()});
      end
      if (txv_m && !rdy_m) begin
        stall_m++;
        if (exp_tx_q.size() != 0) check("stall_data", {8'd0, txd_m}, {8'd0, exp_tx_q[0]});
      end
      if (txv_m && rdy_m) begin
        if (exp_tx_q.size() == 0) fail_extra("extra_word", {8'd0, txd_m});
        else check("tx_data", {8'd0, txd_m}, {8'd0, exp_tx_q.pop_front()});
      end
      if (latch_m) latch_run++;
      else if (prev_latch) begin
        check("latch_len", latch_run, LATCH_M);
        latch_run = 0;
      end
      if (done_m) begin
        done_m_cnt++;
        check("done_after_latch", {30'd0, prev_latch, latch_m}, 32'd2);
        if (exp_follow_q.size() == 0) fail_extra("extra_done", 32'd1);
        else begin
          follow_exp = exp_follow_q.pop_front();
          follow_chk = 1'b1;
        end
      end
      prev_latch = latch_m;
    end
  end

  // ---------------- scoreboard: refresh instance ----------------
  logic [23:0] exp_tx_r_q[$];
  int          exp_gap_q[$];
  int          done_r_cnt = 0;
  int          idle_run   = 0;

  always @(negedge clk) begin
    if (rst_r) begin
      idle_run = 0;
    end else begin
      if (txv_r && rdy_r) begin
        if (exp_tx_r_q.size() == 0) fail_extra("ref_extra_word", {8'd0, txd_r});
        else check("ref_tx_data", {8'd0, txd_r}, {8'd0, exp_tx_r_q.pop_front()});
      end
      if (!busy_r) idle_run++;
      else if (idle_run != 0) begin
        if (exp_gap_q.size() == 0) fail_extra("ref_extra_frame", idle_run);
        else begin
          int g;
          g = exp_gap_q.pop_front();
          if (g != 0) check("ref_idle_gap", idle_run, g);
        end
        idle_run = 0;
      end
      if (done_r) done_r_cnt++;
    end
  end

  // ---------------- scoreboard: single-LED instance ----------------
  logic [23:0] exp_tx_o_q[$];
  int   done_o_cnt  = 0;
  int   rd_o_cnt    = 0;
  int   latch_run_o = 0;
  logic prev_latch_o = 1'b0;

  always @(negedge clk) begin
    if (!rst_o) begin
      if (rd_en_o1) begin
        rd_o_cnt++;
        check("one_rd_addr", {31'd0, addr_o}, 32'd0);
      end
      if (txv_o && rdy_o) begin
        if (exp_tx_o_q.size() == 0) fail_extra("one_extra_word", {8'd0, txd_o});
        else check("one_tx_data", {8'd0, txd_o}, {8'd0, exp_tx_o_q.pop_front()});
      end
      if (latch_o1) latch_run_o++;
      else if (prev_latch_o) begin
        check("one_latch_len", latch_run_o, LATCH_O);
        latch_run_o = 0;
      end
      if (done_o) begin
        done_o_cnt++;
        check("one_done_after_latch", {30'd0, prev_latch_o, latch_o1}, 32'd2);
      end
      prev_latch_o = latch_o1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_update(input int which);
    @(posedge clk); #1;
    case (which)
      0: upd_m = 1'b1;
      1: upd_r = 1'b1;
      default: upd_o = 1'b1;
    endcase
    @(posedge clk); #1;
    upd_m = 1'b0;
    upd_r = 1'b0;
    upd_o = 1'b0;
  endtask

  task automatic push_main_frame(input logic [23:0] w0, input logic [23:0] w1,
                                 input logic [23:0] w2, input logic follow);
    exp_addr_q.push_back(2'd0); exp_addr_q.push_back(2'd1); exp_addr_q.push_back(2'd2);
    exp_tx_q.push_back(w0); exp_tx_q.push_back(w1); exp_tx_q.push_back(w2);
    exp_follow_q.push_back(follow);
  endtask

  task automatic push_ref_frame(input int gap);
    exp_gap_q.push_back(gap);
    exp_tx_r_q.push_back(24'hAB3684);
    exp_tx_r_q.push_back(24'h123456);
    exp_tx_r_q.push_back(24'hFFFFFF);
  endtask

  task automatic wait_main_done(input int target, input int budget);
    int n = 0;
    while (done_m_cnt < target && n < budget) begin @(negedge clk); n++; end
    check("main_done_count", done_m_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_word1_fetch(input string name);
    int n = 0;
    while (!(rd_en_m && addr_m == 2'd1) && n < 100) begin @(negedge clk); n++; end
    check(name, {31'd0, (rd_en_m && addr_m == 2'd1)}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int done_before;
    mem[0] = 24'hAB3684;
    mem[1] = 24'h123456;
    mem[2] = 24'hFFFFFF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {27'd0, rd_en_m, txv_m, latch_m, busy_m, done_m}, 32'd0);
    check("reset_tx_data", {8'd0, txd_m}, 32'd0);
    check("reset_state", {29'd0, st_m}, 32'd0);
    check("ref_reset_state", {29'd0, st_r}, 32'd0);
    check("one_reset_state", {29'd0, st_o}, 32'd0);
    @(posedge clk); #1 rst_m = 1'b0;

    // Basic frame with ready tied high, including first-word latency
    push_main_frame(24'hAB3684, 24'h123456, 24'hFFFFFF, 1'b0);
    pulse_update(0);
    @(negedge clk); check("latency_rd_en", {31'd0, rd_en_m}, 32'd1);
    @(negedge clk); check("latency_no_valid", {31'd0, txv_m}, 32'd0);
    @(negedge clk); check("latency_valid", {31'd0, txv_m}, 32'd1);
    wait_main_done(1, 3000);
    check("basic_queues_empty", exp_tx_q.size() + exp_addr_q.size(), 0);

    // Backpressure on word 1, buffer write to word 2 while stalled
    stall_m = 0;
    push_main_frame(24'hAB3684, 24'h123456, 24'h5A5A5A, 1'b0);
    pulse_update(0);
    wait_word1_fetch("bp_find_word1");
    @(posedge clk); #1 rdy_m = 1'b0;
    @(posedge clk); #1 mem[2] = 24'h5A5A5A;
    repeat (50) @(posedge clk);
    #1 rdy_m = 1'b1;
    wait_main_done(2, 3000);
    check("bp_stall_cycles", stall_m, 50);
    check("bp_queues_empty", exp_tx_q.size() + exp_addr_q.size(), 0);
    mem[2] = 24'hFFFFFF;

    // Coalescing: start, one request during word 0, one during latch
    push_main_frame(24'hAB3684, 24'h123456, 24'hFFFFFF, 1'b1);
    push_main_frame(24'hAB3684, 24'h123456, 24'hFFFFFF, 1'b0);
    pulse_update(0);
    pulse_update(0);
    n = 0;
    while (!latch_m && n < 200) begin @(negedge clk); n++; end
    check("coal_find_latch", {31'd0, latch_m}, 32'd1);
    pulse_update(0);
    wait_main_done(4, 6000);
    check("coal_queues_empty", exp_tx_q.size() + exp_addr_q.size() + exp_follow_q.size(), 0);

    // Reset during SEND of word 1
    push_main_frame(24'hAB3684, 24'h123456, 24'hFFFFFF, 1'b0);
    pulse_update(0);
    wait_word1_fetch("rst_find_word1");
    @(posedge clk); #1 rdy_m = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst_m = 1'b1;
    #1;
    check("async_rst_ctrl", {27'd0, rd_en_m, txv_m, latch_m, busy_m, done_m}, 32'd0);
    check("async_rst_tx_data", {8'd0, txd_m}, 32'd0);
    check("async_rst_addr", {30'd0, addr_m}, 32'd0);
    check("async_rst_state", {29'd0, st_m}, 32'd0);
    exp_tx_q.delete();
    exp_addr_q.delete();
    exp_follow_q.delete();
    done_before = done_m_cnt;
    repeat (3) @(posedge clk);
    #1 rst_m = 1'b0;
    rdy_m = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_m_cnt, done_before);
    push_main_frame(24'hAB3684, 24'h123456, 24'hFFFFFF, 1'b0);
    pulse_update(0);
    wait_main_done(done_before + 1, 3000);
    check("post_rst_queues_empty", exp_tx_q.size() + exp_addr_q.size(), 0);

    // Auto refresh: two automatic frames, an update in IDLE, then another
    push_ref_frame(REF_R);
    push_ref_frame(REF_R);
    @(posedge clk); #1 rst_r = 1'b0;
    n = 0;
    while (done_r_cnt < 2 && n < 12000) begin @(negedge clk); n++; end
    check("ref_auto_frames", done_r_cnt, 2);
    repeat (1000) @(negedge clk);
    push_ref_frame(0);
    push_ref_frame(REF_R);
    pulse_update(1);
    @(negedge clk);
    check("ref_update_start", {30'd0, rd_en_r, busy_r}, 32'd3);
    n = 0;
    while (done_r_cnt < 4 && n < 7000) begin @(negedge clk); n++; end
    check("ref_total_frames", done_r_cnt, 4);
    repeat (2) @(negedge clk);
    check("ref_queues_empty", exp_tx_r_q.size() + exp_gap_q.size(), 0);
    @(posedge clk); #1 rst_r = 1'b1;

    // Single LED
    exp_tx_o_q.push_back(24'hAB3684);
    @(posedge clk); #1 rst_o = 1'b0;
    pulse_update(2);
    n = 0;
    while (done_o_cnt < 1 && n < 200) begin @(negedge clk); n++; end
    check("one_done_count", done_o_cnt, 1);
    repeat (3) @(negedge clk);
    check("one_read_count", rd_o_cnt, 1);
    check("one_idle_after", {31'd0, busy_o1}, 32'd0);
    check("one_queue_empty", exp_tx_o_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences one LED frame out of the I2C-written LED buffer into the serial LED bit driver.
- Fetches each 24-bit colour word in index order and hands it to the serializer over a valid/ready handshake.
- Holds the line in latch/reset for a fixed time after the last word.
- Coalesces update requests that arrive from the I2C slave while a frame is in flight, so no request is lost and none causes a double frame.

Parameters:
- LED_CNT, 3, number of LEDs per frame (≥1).
- LATCH_CYCLES, 2000, clk cycles latch_o is held high after the last word (80 µs at 25 MHz).
- REFRESH_CYCLES, 0, idle cycles before an automatic re-send of the frame; 0 disables auto refresh.
- IDX_W, $clog2(LED_CNT) (min 1), width of the LED index.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- update_i  input  1  one-cycle request from the I2C slave (write ended with STOP).
- rd_en_o  output  1  buffer read strobe.
- rd_addr_o  output  IDX_W  buffer read index.
- rd_data_i  input  24  buffer word, valid exactly 1 cycle after rd_en_o.
- tx_data_o  output  24  colour word to serializer (GRB order as stored).
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  serializer accepts the word.
- latch_o  output  1  serializer must hold the LED line low.
- busy_o  output  1  frame in progress (any state except IDLE).
- frame_done_o  output  1  one-cycle pulse at the end of the latch interval.

Behaviour:
- Reset (async, active-high): state IDLE, idx=0, pending=0, all counters 0. All outputs 0, including tx_data_o=0. Reset mid-frame aborts immediately; no frame_done_o is produced.
- All outputs are registered.
- State machine: IDLE → FETCH → WAIT → SEND → (FETCH | LATCH) → DONE → (FETCH | IDLE).
- IDLE:
  - update_i=1, or the refresh counter reaching REFRESH_CYCLES-1 (only when REFRESH_CYCLES≠0), starts a frame: idx←0, go FETCH.
  - The refresh counter clears on every frame start and runs only in IDLE.
- FETCH: rd_en_o=1 and rd_addr_o=idx for exactly one cycle; go WAIT.
- WAIT: capture rd_data_i into tx_data_o, set tx_valid_o=1, go SEND.
  - Latency: update_i sampled at edge n gives rd_en_o high during cycle n+1 and tx_valid_o high from cycle n+3.
- SEND:
  - Hold tx_valid_o and tx_data_o stable until tx_valid_o&&tx_ready_i.
  - On the handshake cycle, tx_valid_o←0.
  - If idx==LED_CNT-1: go LATCH, latch counter←0. Otherwise idx←idx+1 and go FETCH.
  - tx_ready_i high before tx_valid_o is ignored.
- LATCH: latch_o=1 for exactly LATCH_CYCLES cycles; then go DONE.
- DONE: frame_done_o=1 for one cycle. If pending=1, clear pending, idx←0, go FETCH. Otherwise go IDLE.
- Coalescing:
  - update_i in any state other than IDLE sets pending=1.
  - Multiple requests during one frame collapse into a single follow-up frame.
  - update_i in the same cycle as DONE counts as pending, so the follow-up frame starts from DONE.
- Buffer writes during a frame are allowed. Words not yet fetched take the new value; the block does no snapshotting.
- LED_CNT=1: idx stays 0 and the frame goes SEND → LATCH directly.
- busy_o = (state≠IDLE).

Decomposition:
- Shared package led_pkg holds:
  - state encoding (ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_LATCH, ST_DONE);
  - COLOR_W=24;
  - default LATCH_CYCLES for a 25 MHz clock.
- One sub-module, led_sched_timer: a loadable down-counter with a zero flag. It is instantiated twice, once for latch timing and once for auto refresh.

Test Plan:
- Buffer {0:AB3684, 1:123456, 2:FFFFFF}, update_i pulse, tx_ready_i tied 1.
  - Required: rd_addr_o 0,1,2 in order.
  - Required: tx_data_o AB3684, 123456, FFFFFF, each valid for 1 cycle.
  - Required: latch_o high exactly 2000 cycles, then frame_done_o for one cycle, then busy_o=0.
- Backpressure: tx_ready_i low for 50 cycles on word 1 → tx_valid_o and tx_data_o=123456 stay stable all 50 cycles, the word is accepted once, and no extra read occurs.
- Coalescing: three update_i pulses during word 0 and the latch interval → exactly two frames total and two frame_done_o pulses; the second frame's rd_en_o appears the cycle after the first frame_done_o.
- Reset mid-frame: assert reset during SEND of word 1 → all outputs 0 asynchronously (before the next clk edge), no frame_done_o. A later update_i starts from idx 0.
- Auto refresh: REFRESH_CYCLES=5000, LATCH_CYCLES=100, no update_i → a frame starts every 5000 idle cycles. An update_i in IDLE starts a frame the next cycle and restarts the refresh count.
- LED_CNT=1: single word AB3684 sent, then the latch interval, then frame_done_o; rd_addr_o is always 0.
